// File: rtl/fpu_pkg.sv
// Shared floating-point format constants and converter state encoding.
package fpu_pkg;

    // Single precision format
    localparam int unsigned SP_SIZE  = 32;
    localparam int unsigned SP_EXP_W = 8;
    localparam int unsigned SP_MAN_W = 23;
    localparam int unsigned SP_BIAS  = 127;

    // Double precision format
    localparam int unsigned DP_SIZE  = 64;
    localparam int unsigned DP_EXP_W = 11;
    localparam int unsigned DP_MAN_W = 52;
    localparam int unsigned DP_BIAS  = 1023;

    // Result width for the selected precision
    function automatic int unsigned fpu_size(input bit dbl);
        return dbl ? DP_SIZE : SP_SIZE;
    endfunction

    // Exponent field width for the selected precision
    function automatic int unsigned fpu_exp_w(input bit dbl);
        return dbl ? DP_EXP_W : SP_EXP_W;
    endfunction

    // Fraction field width for the selected precision
    function automatic int unsigned fpu_man_w(input bit dbl);
        return dbl ? DP_MAN_W : SP_MAN_W;
    endfunction

    // Exponent bias for the selected precision
    function automatic int unsigned fpu_bias(input bit dbl);
        return dbl ? DP_BIAS : SP_BIAS;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/int_to_fpu.sv
// Iterative signed-integer to IEEE-754 converter, round-toward-zero,
// normalising one bit per cycle.
module int_to_fpu
    import fpu_pkg::*;
#(
    parameter bit          double    = 1'b0,
    parameter int unsigned int_width = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [int_width-1:0]          in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [fpu_size(double)-1:0]   result,
    output logic                          inexact
);

    localparam int unsigned SIZE     = fpu_size(double);
    localparam int unsigned EXP_W    = fpu_exp_w(double);
    localparam int unsigned MAN_W    = fpu_man_w(double);
    localparam int unsigned BIAS     = fpu_bias(double);
    localparam int unsigned IW       = int_width;
    localparam int unsigned EXT_W    = IW - 1 + MAN_W;
    localparam int unsigned EXP_INIT = BIAS + IW - 1;

    state_t             state, state_n;
    logic               sign, sign_n;
    logic [IW-1:0]      mag, mag_n;
    logic [EXP_W-1:0]   exp, exp_n;
    logic [SIZE-1:0]    result_n;
    logic               inexact_n;

    // Magnitude bits below the hidden one, MSB-aligned and zero-extended
    // so the fraction and the discarded tail can be sliced uniformly.
    logic [EXT_W-1:0]   ext;
    logic [MAN_W-1:0]   frac;
    logic               lost;

    // Fraction field extraction and truncation detection
    always_comb begin
        ext  = {mag[IW-2:0], {MAN_W{1'b0}}};
        frac = ext[EXT_W-1 -: MAN_W];
        lost = |ext[IW-2:0];
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sign      <= 1'b0;
            mag       <= '0;
            exp       <= '0;
            result    <= '0;
            inexact   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            sign      <= sign_n;
            mag       <= mag_n;
            exp       <= exp_n;
            result    <= result_n;
            inexact   <= inexact_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n   = state;
        sign_n    = sign;
        mag_n     = mag;
        exp_n     = exp;
        result_n  = result;
        inexact_n = inexact;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_n = in_data[IW-1];
                    // Unsigned negate: the most negative sample wraps onto 2^(IW-1)
                    mag_n  = in_data[IW-1] ? (IW'(~in_data) + IW'(1)) : in_data;
                    exp_n  = EXP_W'(EXP_INIT);
                    if (mag_n == '0) begin
                        result_n  = '0;
                        inexact_n = 1'b0;
                        state_n   = DONE;
                    end else begin
                        state_n   = NORM;
                    end
                end
            end
            NORM: begin
                if (mag[IW-1]) begin
                    result_n  = {sign, exp, frac};
                    inexact_n = lost;
                    state_n   = DONE;
                end else begin
                    mag_n = {mag[IW-2:0], 1'b0};
                    exp_n = exp - EXP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_int_to_fpu.sv
// Directed-vector bench for int_to_fpu in single and double precision.
module tb_int_to_fpu;

    logic        clk;
    logic        rst;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_result;
    logic        s_inexact;

    logic        d_in_valid;
    logic        d_in_ready;
    logic [31:0] d_in_data;
    logic        d_out_valid;
    logic        d_out_ready;
    logic [63:0] d_result;
    logic        d_inexact;

    int vectors;
    int miscompares;

    int_to_fpu #(.double(1'b0), .int_width(32)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .result    (s_result),
        .inexact   (s_inexact)
    );

    int_to_fpu #(.double(1'b1), .int_width(32)) dut_d (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_data   (d_in_data),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .result    (d_result),
        .inexact   (d_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer a sample to the single-precision DUT, return accept flag and latency
    task automatic send_s(input logic [31:0] data, output bit acc, output int lat);
        bit rdy;
        s_in_data  = data;
        s_in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            rdy = s_in_ready;
            @(posedge clk); #1;
            if (rdy) acc = 1'b1;
        end
        s_in_valid = 1'b0;
        lat = 0;
        while (acc && !s_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Offer a sample to the double-precision DUT, return accept flag and latency
    task automatic send_d(input logic [31:0] data, output bit acc, output int lat);
        bit rdy;
        d_in_data  = data;
        d_in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            rdy = d_in_ready;
            @(posedge clk); #1;
            if (rdy) acc = 1'b1;
        end
        d_in_valid = 1'b0;
        lat = 0;
        while (acc && !d_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Pulse out_ready for one edge on both DUTs
    task automatic drain;
        s_out_ready = 1'b1;
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        d_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_result !== 32'h0 || s_inexact !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_s: rdy=%b vld=%b res=%h inx=%b, required rdy=1 vld=0 res=0 inx=0",
                     s_in_ready, s_out_valid, s_result, s_inexact);
        end
        vectors++;
        if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0 || d_result !== 64'h0 || d_inexact !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_d: rdy=%b vld=%b res=%h inx=%b, required rdy=1 vld=0 res=0 inx=0",
                     d_in_ready, d_out_valid, d_result, d_inexact);
        end
    endtask

    task automatic test_single;
        logic [31:0] din  [8] = '{32'h1, 32'h3, 32'hFFFFFFFF, 32'h0,
                                  32'h80000000, 32'h7FFFFFFF, 32'd100, 32'hFFFFFFF8};
        logic [31:0] eres [8] = '{32'h3F800000, 32'h40400000, 32'hBF800000, 32'h00000000,
                                  32'hCF000000, 32'h4EFFFFFF, 32'h42C80000, 32'hC1000000};
        logic        einx [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          elat [8] = '{32, 31, 32, 0, 1, 2, 26, 29};
        bit acc;
        int lat;
        for (int i = 0; i < 8; i++) begin
            send_s(din[i], acc, lat);
            vectors++;
            if (!acc || !s_out_valid) begin
                miscompares++;
                $display("FAIL single_handshake[%0d]: acc=%b vld=%b, required acc=1 vld=1", i, acc, s_out_valid);
            end
            vectors++;
            if (lat != elat[i]) begin
                miscompares++;
                $display("FAIL single_latency[%0d]: got %0d, required %0d", i, lat, elat[i]);
            end
            vectors++;
            if (s_result !== eres[i] || s_inexact !== einx[i]) begin
                miscompares++;
                $display("FAIL single_result[%0d]: got %h inx=%b, required %h inx=%b",
                         i, s_result, s_inexact, eres[i], einx[i]);
            end
            drain();
            vectors++;
            if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL single_release[%0d]: rdy=%b vld=%b, required rdy=1 vld=0", i, s_in_ready, s_out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        bit acc;
        int lat;
        send_s(32'd5, acc, lat);
        vectors++;
        if (!acc || lat != 30 || s_result !== 32'h40A00000) begin
            miscompares++;
            $display("FAIL bp_first: acc=%b lat=%0d res=%h, required acc=1 lat=30 res=40a00000", acc, lat, s_result);
        end
        s_in_data  = 32'd7;
        s_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_result !== 32'h40A00000 || s_inexact !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h inx=%b, required vld=1 rdy=0 res=40a00000 inx=0",
                         i, s_out_valid, s_in_ready, s_result, s_inexact);
            end
        end
        drain();
        vectors++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: rdy=%b vld=%b, required rdy=1 vld=0", s_in_ready, s_out_valid);
        end
        send_s(32'd7, acc, lat);
        vectors++;
        if (!acc || lat != 30 || s_result !== 32'h40E00000) begin
            miscompares++;
            $display("FAIL bp_next: acc=%b lat=%0d res=%h, required acc=1 lat=30 res=40e00000", acc, lat, s_result);
        end
        drain();
    endtask

    task automatic test_reset_mid_norm;
        bit acc;
        int lat;
        s_in_data  = 32'd1;
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_busy: rdy=%b vld=%b, required rdy=0 vld=0", s_in_ready, s_out_valid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_result !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: rdy=%b vld=%b res=%h, required rdy=1 vld=0 res=0",
                     s_in_ready, s_out_valid, s_result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_s(32'd2, acc, lat);
        vectors++;
        if (!acc || lat != 31 || s_result !== 32'h40000000 || s_inexact !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after: acc=%b lat=%0d res=%h inx=%b, required acc=1 lat=31 res=40000000 inx=0",
                     acc, lat, s_result, s_inexact);
        end
        drain();
    endtask

    task automatic test_double;
        logic [31:0] din  [4] = '{32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic [63:0] eres [4] = '{64'h3FF0000000000000, 64'h41DFFFFFFFC00000,
                                  64'hC1E0000000000000, 64'hBFF0000000000000};
        int          elat [4] = '{32, 2, 1, 32};
        bit acc;
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_d(din[i], acc, lat);
            vectors++;
            if (!acc || lat != elat[i]) begin
                miscompares++;
                $display("FAIL double_latency[%0d]: acc=%b lat=%0d, required acc=1 lat=%0d", i, acc, lat, elat[i]);
            end
            vectors++;
            if (d_result !== eres[i] || d_inexact !== 1'b0) begin
                miscompares++;
                $display("FAIL double_result[%0d]: got %h inx=%b, required %h inx=0", i, d_result, d_inexact, eres[i]);
            end
            drain();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b0;
        d_in_valid  = 1'b0;
        d_in_data   = '0;
        d_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_single();
        test_backpressure();
        test_reset_mid_norm();
        test_double();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
